// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file target.
//   i2c_tgt_state_t : protocol FSM states
//   I2C_ACK/I2C_NACK: bus level of the acknowledge bit
//   I2C_RW_BIT      : position of the R/W flag in the address byte
//   I2C_BYTE_BITS   : data bits per byte, as a bit-counter value
//   clog2()         : pointer-width helper (returns at least 1)
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic       I2C_ACK       = 1'b0;
  localparam logic       I2C_NACK      = 1'b1;
  localparam int         I2C_RW_BIT    = 0;
  localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and bus-event detector for the SCL/SDA pair.
// Each line passes through SYNC_STAGES flops, then one history flop; all
// events are decoded from the synchronised value and its history.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   scl_i, sda_i   raw pin inputs (asynchronous)
//   sda_o          synchronised SDA level
//   scl_rise_o     one-cycle pulse on synchronised SCL rising edge
//   scl_fall_o     one-cycle pulse on synchronised SCL falling edge
//   start_o        SDA fell while SCL was high (START / repeated START)
//   stop_o         SDA rose while SCL was high (STOP)
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  logic                   scl_s, sda_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign scl_sync_d[gi] = scl_i;
        assign sda_sync_d[gi] = sda_i;
      end else begin : g_chain
        assign scl_sync_d[gi] = scl_sync_q[gi-1];
        assign sda_sync_d[gi] = sda_sync_q[gi-1];
      end
    end
  endgenerate

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_hist_d = scl_s;
  assign sda_hist_d = sda_s;

  // Idle bus is high on both lines; resetting to 1 avoids a phantom
  // START/STOP or SCL edge as the chain fills after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  // SCL must be high both now and in the history sample, so an SDA change
  // that races an SCL edge is never taken as START/STOP.
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a DEPTH x 8-bit register file.
// Bus protocol: [addr+W][pointer][data...] writes with auto-increment;
// [addr+R][data...] reads from the current pointer with auto-increment.
// A repeated START keeps the pointer, so pointer-write then read works.
// Ports:
//   clk, rst      system clock (>= 8x SCL), asynchronous active-high reset
//   scl_i, sda_i  raw bus pins
//   sda_oe        1 = pull SDA low, 0 = release
//   wr_stb        one-cycle pulse for every register written from the bus
//   wr_addr       register index of the last bus write
//   wr_data       data of the last bus write
//   rd_idx        local read-back index
//   rd_val        regs[rd_idx] (combinational)
//   busy          set when addressed, cleared on STOP or when this target NACKs
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [PW-1:0] rd_idx,
  output logic [7:0]    rd_val,
  output logic          busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           rw_q, rw_d;
  logic           mack_q, mack_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;
  logic           wr_stb_q, wr_stb_d;
  logic [PW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;

  logic [7:0]     regs_q [DEPTH];
  logic [7:0]     regs_d [DEPTH];
  logic           reg_we;

  logic           rx_state;
  logic           byte_done;
  logic [7:0]     rd_cur;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // States that shift in a byte from the controller.
  assign rx_state  = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);
  // A received byte is acted on at the SCL fall after its 8th bit, which is
  // exactly when the acknowledge level must appear on SDA.
  assign byte_done = scl_fall && (bit_cnt_q == I2C_BYTE_BITS);
  assign rd_cur    = regs_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg_we    = 1'b0;

    if (stop_det) begin
      // Any partial byte is simply abandoned; nothing is written.
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      // START or repeated START; the pointer is deliberately kept.
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      if (rx_state && scl_rise && (bit_cnt_q != I2C_BYTE_BITS)) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end

      case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = (I2C_ACK == 1'b0);
              busy_d   = 1'b1;
              rw_d     = shift_q[I2C_RW_BIT];
            end else begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              // First read bit goes out on the same fall that ends the ACK.
              state_d   = ST_RDATA;
              sda_oe_d  = ~rd_cur[7];
              shift_d   = {rd_cur[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = ST_PTR;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end

        ST_PTR: begin
          if (byte_done) begin
            bit_cnt_d = '0;
            if ({1'b0, shift_q} < 9'(DEPTH)) begin
              state_d  = ST_PTR_ACK;
              ptr_d    = shift_q[PW-1:0];
              sda_oe_d = (I2C_ACK == 1'b0);
            end else begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = ST_WDATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end

        ST_WDATA: begin
          if (byte_done) begin
            bit_cnt_d = '0;
            reg_we    = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_q;
            ptr_d     = ptr_inc(ptr_q);
            sda_oe_d  = (I2C_ACK == 1'b0);
            state_d   = ST_WDATA_ACK;
          end
        end

        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == I2C_BYTE_BITS) begin
              // Release so the controller can drive its ACK/NACK.
              state_d   = ST_RD_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_RD_ACK: begin
          // Pointer advances at the ACK rise so rd_cur already holds the
          // next byte when the following fall reloads the shifter.
          if (scl_rise) begin
            mack_d = sda_s;
            if (sda_s == I2C_ACK) ptr_d = ptr_inc(ptr_q);
          end else if (scl_fall) begin
            if (mack_q == I2C_ACK) begin
              state_d   = ST_RDATA;
              sda_oe_d  = ~rd_cur[7];
              shift_d   = {rd_cur[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_IDLE, ST_WAIT_STOP: begin
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_we) regs_d[ptr_q] = shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      mack_q    <= I2C_NACK;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign rd_val  = regs_q[rd_idx];

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr, rd_idx;
  logic [7:0] wr_data, rd_val;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;  // open-drain wired-AND

  i2c_target_regfile #(
    .TARGET_ADDR(7'h50),
    .DEPTH      (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_m),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_idx (rd_idx),
    .rd_val (rd_val),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;
  logic [3:0] wlog_a[$];
  logic [7:0] wlog_d[$];
  logic [3:0] exp_a[$];
  logic [7:0] exp_d[$];
  logic [7:0] exp_regs[16];

  always @(negedge clk) begin
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
    if (wr_stb) begin
      wlog_a.push_back(wr_addr);
      wlog_d.push_back(wr_data);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum int {K_START, K_STOP, K_WR, K_RD} kind_e;
  typedef struct {
    int         test;
    kind_e      kind;
    logic [7:0] data;      // WR: byte sent; RD: controller ACK bit in [0]
    logic [7:0] exp;       // WR: expected ACK level; RD: expected byte
    logic       exp_busy;  // busy after the step
  } step_t;
  step_t steps[$];

  task automatic add(input int t, input kind_e k, input logic [7:0] d,
                     input logic [7:0] e, input logic b);
    step_t s;
    s.test = t; s.kind = k; s.data = d; s.exp = e; s.exp_busy = b;
    steps.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    s = sda_line;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], dummy);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v);
    logic s;
    logic dummy;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      v[i] = s;
    end
    clock_bit(mack, dummy);
  endtask

  task automatic run_test(input int t);
    logic       ack;
    logic [7:0] got;
    for (int i = 0; i < steps.size(); i++) begin
      if (steps[i].test == t) begin
        got = 8'h00;
        case (steps[i].kind)
          K_START: i2c_start();
          K_STOP:  i2c_stop();
          K_WR: begin
            write_byte(steps[i].data, ack);
            got = {7'b0, ack};
            chk8($sformatf("t%0d s%0d ack", t, i), got, steps[i].exp);
          end
          K_RD: begin
            read_byte(steps[i].data[0], got);
            chk8($sformatf("t%0d s%0d rdata", t, i), got, steps[i].exp);
          end
          default: ;
        endcase
        chk8($sformatf("t%0d s%0d busy", t, i), {7'b0, busy}, {7'b0, steps[i].exp_busy});
        $display("test %0d step %0d %s data=0x%02h got=0x%02h busy=%0b",
                 t, i, steps[i].kind.name(), steps[i].data, got, busy);
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #2;
      chk8($sformatf("%s rd_val[%0d]", tag, i), rd_val, exp_regs[i]);
    end
  endtask

  task automatic check_wlog(input string tag);
    chk_int({tag, " wr_stb count"}, wlog_a.size(), exp_a.size());
    for (int i = 0; i < wlog_a.size() && i < exp_a.size(); i++) begin
      chk8($sformatf("%s wr_addr#%0d", tag, i), {4'b0, wlog_a[i]}, {4'b0, exp_a[i]});
      chk8($sformatf("%s wr_data#%0d", tag, i), wlog_d[i], exp_d[i]);
    end
    wlog_a.delete(); wlog_d.delete();
    exp_a.delete();  exp_d.delete();
  endtask

  initial begin
    // 1: pointer-then-data write
    add(1, K_START, 8'h00, 8'h00, 1'b0);
    add(1, K_WR,    8'hA0, 8'h00, 1'b1);
    add(1, K_WR,    8'h03, 8'h00, 1'b1);
    add(1, K_WR,    8'h11, 8'h00, 1'b1);
    add(1, K_WR,    8'h22, 8'h00, 1'b1);
    add(1, K_STOP,  8'h00, 8'h00, 1'b0);
    // 2: set pointer, repeated START, read two bytes ACK/NACK
    add(2, K_START, 8'h00, 8'h00, 1'b0);
    add(2, K_WR,    8'hA0, 8'h00, 1'b1);
    add(2, K_WR,    8'h03, 8'h00, 1'b1);
    add(2, K_START, 8'h00, 8'h00, 1'b1);
    add(2, K_WR,    8'hA1, 8'h00, 1'b1);
    add(2, K_RD,    8'h00, 8'h11, 1'b1);
    add(2, K_RD,    8'h01, 8'h22, 1'b1);
    add(2, K_STOP,  8'h00, 8'h00, 1'b0);
    // 3: foreign address 0x42
    add(3, K_START, 8'h00, 8'h00, 1'b0);
    add(3, K_WR,    8'h84, 8'h01, 1'b0);
    add(3, K_WR,    8'h03, 8'h01, 1'b0);
    add(3, K_WR,    8'h55, 8'h01, 1'b0);
    add(3, K_STOP,  8'h00, 8'h00, 1'b0);
    // 4: write wrap from the last register
    add(4, K_START, 8'h00, 8'h00, 1'b0);
    add(4, K_WR,    8'hA0, 8'h00, 1'b1);
    add(4, K_WR,    8'h0F, 8'h00, 1'b1);
    add(4, K_WR,    8'hAA, 8'h00, 1'b1);
    add(4, K_WR,    8'hBB, 8'h00, 1'b1);
    add(4, K_STOP,  8'h00, 8'h00, 1'b0);
    // 5: out-of-range pointer
    add(5, K_START, 8'h00, 8'h00, 1'b0);
    add(5, K_WR,    8'hA0, 8'h00, 1'b1);
    add(5, K_WR,    8'h20, 8'h01, 1'b0);
    add(5, K_WR,    8'h77, 8'h01, 1'b0);
    add(5, K_STOP,  8'h00, 8'h00, 1'b0);
    // 6: read wrap from the last register
    add(6, K_START, 8'h00, 8'h00, 1'b0);
    add(6, K_WR,    8'hA0, 8'h00, 1'b1);
    add(6, K_WR,    8'h0F, 8'h00, 1'b1);
    add(6, K_START, 8'h00, 8'h00, 1'b1);
    add(6, K_WR,    8'hA1, 8'h00, 1'b1);
    add(6, K_RD,    8'h00, 8'hAA, 1'b1);
    add(6, K_RD,    8'h01, 8'hBB, 1'b1);
    add(6, K_STOP,  8'h00, 8'h00, 1'b0);
    // 7: start a read of reg 3 (0x11, MSB 0) and stop there
    add(7, K_START, 8'h00, 8'h00, 1'b0);
    add(7, K_WR,    8'hA0, 8'h00, 1'b1);
    add(7, K_WR,    8'h03, 8'h00, 1'b1);
    add(7, K_START, 8'h00, 8'h00, 1'b1);
    add(7, K_WR,    8'hA1, 8'h00, 1'b1);
    // 8: bus recovery and a normal write after reset
    add(8, K_STOP,  8'h00, 8'h00, 1'b0);
    add(8, K_START, 8'h00, 8'h00, 1'b0);
    add(8, K_WR,    8'hA0, 8'h00, 1'b1);
    add(8, K_WR,    8'h03, 8'h00, 1'b1);
    add(8, K_WR,    8'h44, 8'h00, 1'b1);
    add(8, K_STOP,  8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    rd_idx = 4'd0;

    // Reset state
    tick(4);
    chk8("reset sda_oe",  {7'b0, sda_oe}, 8'h00);
    chk8("reset wr_stb",  {7'b0, wr_stb}, 8'h00);
    chk8("reset wr_addr", {4'b0, wr_addr}, 8'h00);
    chk8("reset wr_data", wr_data, 8'h00);
    chk8("reset busy",    {7'b0, busy}, 8'h00);
    check_regs("reset");
    rst = 1'b0;
    tick(4);
    wlog_a.delete(); wlog_d.delete();

    run_test(1);
    exp_a.push_back(4'd3); exp_d.push_back(8'h11);
    exp_a.push_back(4'd4); exp_d.push_back(8'h22);
    check_wlog("t1");
    exp_regs[3] = 8'h11;
    exp_regs[4] = 8'h22;
    check_regs("t1");

    run_test(2);
    check_wlog("t2");

    oe_cycles = 0;
    busy_cycles = 0;
    run_test(3);
    chk_int("t3 sda_oe cycles", oe_cycles, 0);
    chk_int("t3 busy cycles", busy_cycles, 0);
    check_wlog("t3");

    run_test(4);
    exp_a.push_back(4'd15); exp_d.push_back(8'hAA);
    exp_a.push_back(4'd0);  exp_d.push_back(8'hBB);
    check_wlog("t4");
    exp_regs[15] = 8'hAA;
    exp_regs[0]  = 8'hBB;
    check_regs("t4");

    run_test(5);
    check_wlog("t5");
    check_regs("t5");

    run_test(6);
    check_wlog("t6");

    run_test(7);
    chk8("t7 driving bit7=0", {7'b0, sda_oe}, 8'h01);
    #3;
    rst = 1'b1;
    #1;
    chk8("t7 async release", {7'b0, sda_oe}, 8'h00);
    chk8("t7 busy in reset", {7'b0, busy}, 8'h00);
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    check_regs("t7");
    tick(3);
    rst = 1'b0;
    tick(2);
    check_wlog("t7");

    run_test(8);
    exp_a.push_back(4'd3); exp_d.push_back(8'h44);
    check_wlog("t8");
    exp_regs[3] = 8'h44;
    check_regs("t8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
